cp0_exc_unit: RTL and testbench
===============================

# cp0_exc_unit

Parametrised coprocessor-0 exception unit for the multi-cycle/pipelined MIPS core. It extends the single-EXL/EPC controller with Status, Cause, Count and Compare registers and an EPC register that is aware of branch delay slots. It also adds maskable hardware interrupts, a cycle timer interrupt, and mfc0/mtc0 access. It sits beside the PC/next-PC logic and supplies the exception target, the return address and the interrupt request.

## Interface
- `NUM_HWINT`, 6: number of external interrupt lines, 1..6, mapped to Cause.IP[10 +: NUM_HWINT].
- `HANDLER_ADDR`, 32'h0000_01a0: exception entry address.
- `COUNT_DIV`, 2: clock cycles per Count increment, ≥1.
- `PRID`, 32'h0001_8000: read-only PRId value.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous reset, active-high.
- `PC` in 32: PC of the faulting/interrupted instruction.
- `is_bd` in 1: that instruction is in a branch delay slot.
- `exc_req` in 1: synchronous exception from the core.
- `exc_code` in 5: ExcCode for `exc_req`.
- `eret` in 1: eret executing; clears EXL.
- `we` in 1: mtc0 write strobe.
- `addr` in 5: CP0 register number for mfc0/mtc0.
- `wdata` in 32: mtc0 data.
- `rdata` out 32: mfc0 data, combinational from `addr`.
- `hw_int` in NUM_HWINT: level-sensitive external interrupts.
- `int_req` out 1: interrupt pending and enabled; the core must take entry.
- `exc_enter` out 1: combinational, high when entry occurs at this edge.
- `EPC` out 32: exception return address.
- `handler_PC` out 32: constant `HANDLER_ADDR`.
- `exl` out 1: Status.EXL.

## Operation
- Registers by number:
  - Count (9): R/W.
  - Compare (11): R/W.
  - Status (12): IM[15:8], EXL[1] and IE[0] are writable. All other bits read 0.
  - Cause (13): BD[31], TI[30], IP[15:8] and ExcCode[6:2]. Only IP[9:8] (software interrupts) are writable.
  - EPC (14): R/W.
  - PRId (15): reads `PRID`.
- Any other address reads 0 and ignores writes.
- `int_req` = IE & ~EXL & |(Cause.IP & Status.IM).
- Entry: `exc_enter` = `exc_req | int_req`. At the edge:
  - EXL is set.
  - ExcCode is loaded with `exc_code` if `exc_req` is high, otherwise with 0 (Int).
  - If EXL was 0: EPC ← `is_bd` ? PC−4 : PC, and BD ← `is_bd`.
  - If EXL was already 1: EPC and BD are held and only ExcCode is updated.
- eret: EXL is cleared. EPC is unchanged.
- Hardware interrupts: Cause.IP[10 +: NUM_HWINT] are registered from `hw_int` every cycle. They are not latched, so clearing the source clears the bit. Unused IP bits read 0.
- Timer:
  - A prescaler counts 0..COUNT_DIV−1. Count increments when the prescaler wraps.
  - Count wraps modulo 2^32.
  - TI is set the cycle after Count == Compare on an increment.
  - TI is ORed into IP[15] regardless of NUM_HWINT.
  - TI is cleared only by an mtc0 write to Compare.
- Priority per edge: `rst` > entry > eret > mtc0.
  - An mtc0 or eret in the same cycle as entry is discarded, because the instruction is being cancelled.
  - An mtc0 write to Count overrides the increment and resets the prescaler.
- Reset values:
  - Status, Cause, EPC, Count, Compare, TI and prescaler all 0.
  - `exl` = 0, `int_req` = 0, `EPC` = 0.
  - `handler_PC` = HANDLER_ADDR at all times.

## Timing
- mtc0 takes effect at the edge of `we`. A same-cycle mfc0 of that register returns the old value; the next cycle returns the new value.
- `hw_int` high in cycle n gives IP set after edge n, so `int_req` is high in cycle n+1 if enabled.
- EPC, EXL and ExcCode are visible the cycle after the entry edge. `handler_PC` needs no latency.
- `rst` high mid-entry: reset wins and no state is captured.
- With EXL=1, `int_req` stays 0 whatever IP and IE are.
- At Count = 32'hFFFF_FFFF with Compare = 0: Count wraps to 0, then TI is set.

## Test plan
- Reset, then read all registers: each returns 0, PRId returns 32'h0001_8000, `handler_PC` is 32'h1a0.
- Apply `exc_req`, `exc_code`=5'd8, PC=32'h100, `is_bd`=0. Expected: EPC=32'h100, EXL=1, ExcCode=8. Then `eret`: EXL=0 and EPC stays 32'h100.
- Apply `exc_req` with PC=32'h204 and `is_bd`=1. Expected: EPC=32'h200, BD=1. Then a second `exc_req` with code 12 while EXL=1: EPC stays 32'h200 and ExcCode=12.
- Status=32'h0000_0401 (IM2, IE), then raise `hw_int`[0]. Expected: `int_req` high exactly one cycle after assertion. Entry records ExcCode=0, and `int_req` drops while EXL=1.
- Set COUNT_DIV=2, Count=0, Compare=3. Expected: TI set after about 7 cycles and IP[15] set. A write to Compare clears TI.
- In one cycle, assert `we` to Status with 0, together with `exc_req`. Expected: entry occurs and the Status write is dropped, so IE/IM keep their prior values.

Source files
------------

// File: rtl/cp0_exc_unit.sv
// rtl/cp0_exc_unit.sv - CP0 exception unit: Status/Cause/EPC/Count/Compare, interrupts, mfc0/mtc0
module cp0_exc_unit #(
  parameter int          NUM_HWINT    = 6,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_01a0,
  parameter int          COUNT_DIV    = 2,
  parameter logic [31:0] PRID         = 32'h0001_8000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          PC,
  input  logic                 is_bd,
  input  logic                 exc_req,
  input  logic [4:0]           exc_code,
  input  logic                 eret,
  input  logic                 we,
  input  logic [4:0]           addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  input  logic [NUM_HWINT-1:0] hw_int,
  output logic                 int_req,
  output logic                 exc_enter,
  output logic [31:0]          EPC,
  output logic [31:0]          handler_PC,
  output logic                 exl
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

  logic [31:0]          count, compare, epc_r;
  logic [7:0]           im;
  logic                 ie, exl_r, bd, ti, cnt_hit;
  logic [1:0]           ip_sw;
  logic [NUM_HWINT-1:0] ip_hw;
  logic [4:0]           code;
  logic [PW-1:0]        presc;
  logic [7:0]           ip;
  logic [31:0]          count_inc;
  logic                 tick, wr_ok;
  logic                 unused_wdata;

  // TI shares IP[15] with the top hardware line when all six are present
  assign ip        = {ti, 7'b0} | {6'b0, ip_sw} | (8'(ip_hw) << 2);
  assign int_req   = ie & ~exl_r & (|(ip & im));
  assign exc_enter = exc_req | int_req;
  assign wr_ok     = we & ~exc_enter & ~eret;
  assign tick      = (presc == PRESC_MAX);
  assign count_inc = count + 32'd1;

  assign EPC        = epc_r;
  assign exl        = exl_r;
  assign handler_PC = HANDLER_ADDR;
  assign unused_wdata = ^{wdata[31:16], wdata[7:2]};

  always_comb begin
    rdata = 32'd0;
    case (addr)
      5'd9:    rdata = count;
      5'd11:   rdata = compare;
      5'd12:   rdata = {16'b0, im, 6'b0, exl_r, ie};
      5'd13:   rdata = {bd, ti, 14'b0, ip, 1'b0, code, 2'b0};
      5'd14:   rdata = epc_r;
      5'd15:   rdata = PRID;
      default: rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      compare <= '0;
      epc_r   <= '0;
      im      <= '0;
      ie      <= 1'b0;
      exl_r   <= 1'b0;
      bd      <= 1'b0;
      ti      <= 1'b0;
      cnt_hit <= 1'b0;
      ip_sw   <= '0;
      ip_hw   <= '0;
      code    <= '0;
      presc   <= '0;
    end else begin
      ip_hw <= hw_int;

      // A Count write restarts the prescaler and suppresses that edge's increment
      if (wr_ok && addr == 5'd9) begin
        count   <= wdata;
        presc   <= '0;
        cnt_hit <= 1'b0;
      end else if (tick) begin
        count   <= count_inc;
        presc   <= '0;
        cnt_hit <= (count_inc == compare);
      end else begin
        presc   <= presc + PW'(1);
        cnt_hit <= 1'b0;
      end

      if (wr_ok && addr == 5'd11) begin
        compare <= wdata;
        ti      <= 1'b0;
      end else if (cnt_hit) begin
        ti <= 1'b1;
      end

      if (exc_enter) begin
        exl_r <= 1'b1;
        code  <= exc_req ? exc_code : 5'd0;
        if (!exl_r) begin
          epc_r <= is_bd ? PC - 32'd4 : PC;
          bd    <= is_bd;
        end
      end else if (eret) begin
        exl_r <= 1'b0;
      end else if (we) begin
        case (addr)
          5'd12: begin
            im    <= wdata[15:8];
            exl_r <= wdata[1];
            ie    <= wdata[0];
          end
          5'd13:   ip_sw <= wdata[9:8];
          5'd14:   epc_r <= wdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb/tb_cp0_exc_unit.sv - vector table, corner sequences and randomized model check for cp0_exc_unit
module tb_cp0_exc_unit;
  localparam int CDIV = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC, wdata, rdata, EPC, handler_PC;
  logic        is_bd, exc_req, eret, we, int_req, exc_enter, exl;
  logic [4:0]  exc_code, addr;
  logic [5:0]  hw_int;

  int n_cmp = 0;
  int n_bad = 0;

  cp0_exc_unit #(.NUM_HWINT(6), .HANDLER_ADDR(32'h0000_01a0), .COUNT_DIV(CDIV),
                 .PRID(32'h0001_8000)) dut (
    .clk(clk), .rst(rst), .PC(PC), .is_bd(is_bd), .exc_req(exc_req), .exc_code(exc_code),
    .eret(eret), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata), .hw_int(hw_int),
    .int_req(int_req), .exc_enter(exc_enter), .EPC(EPC), .handler_PC(handler_PC), .exl(exl));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    we = 0; addr = 5'd0; wdata = 0; exc_req = 0; exc_code = 0; eret = 0;
    PC = 0; is_bd = 0; hw_int = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        exc;
    logic [4:0]  code;
    logic        eret;
    logic [31:0] pc;
    logic        bd;
    logic [5:0]  hw;
    logic [31:0] e_rdata;
    logic        e_int;
    logic        e_enter;
    logic        e_exl;
    logic [31:0] e_epc;
  } vec_t;

  vec_t tv[29];

  // Behavioural model: architectural register fields, updated once per edge
  bit [31:0] m_count, m_compare, m_epc;
  bit [7:0]  m_im;
  bit        m_ie, m_exl, m_bd, m_ti, m_pend;
  bit [1:0]  m_sw;
  bit [5:0]  m_hw;
  bit [4:0]  m_code;
  int        m_edges;

  function automatic bit [7:0] m_ip();
    return {m_ti | m_hw[5], m_hw[4:0], m_sw};
  endfunction

  function automatic bit m_int();
    return m_ie && !m_exl && ((m_ip() & m_im) != 8'd0);
  endfunction

  function automatic bit [31:0] m_read(input bit [4:0] a);
    case (a)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
      5'd13:   return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip()) << 8) | (32'(m_code) << 2);
      5'd14:   return m_epc;
      5'd15:   return 32'h0001_8000;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_count = 0; m_compare = 0; m_epc = 0; m_im = 0; m_ie = 0; m_exl = 0; m_bd = 0;
    m_ti = 0; m_pend = 0; m_sw = 0; m_hw = 0; m_code = 0; m_edges = 0;
  endtask

  task automatic m_step();
    bit ent, mt, old_pend;
    ent = exc_req || m_int();
    mt = we && !ent && !eret;
    old_pend = m_pend;
    m_pend = 0;
    m_edges++;
    if (mt && addr == 5'd9) begin
      m_count = wdata;
      m_edges = 0;
    end else if (m_edges % CDIV == 0) begin
      m_count = m_count + 1;
      m_pend = (m_count == m_compare);
    end
    if (mt && addr == 5'd11) begin
      m_compare = wdata;
      m_ti = 0;
    end else if (old_pend) m_ti = 1;
    if (ent) begin
      if (!m_exl) begin
        m_epc = is_bd ? PC - 4 : PC;
        m_bd = is_bd;
      end
      m_exl = 1;
      m_code = exc_req ? exc_code : 5'd0;
    end else if (eret) m_exl = 0;
    else if (mt && addr == 5'd12) begin
      m_im = wdata[15:8]; m_exl = wdata[1]; m_ie = wdata[0];
    end else if (mt && addr == 5'd13) m_sw = wdata[9:8];
    else if (mt && addr == 5'd14) m_epc = wdata;
    m_hw = hw_int;
  endtask

  initial begin
    //          we addr   wdata         exc code  eret pc            bd hw  rdata         int en exl epc
    tv[0]  = '{0, 5'd9,  32'h0,        0, 5'd0,  0, 32'h0,       0, 6'd0, 32'h0,        0, 0, 0, 32'h0};
    tv[1]  = '{0, 5'd15, 32'h0,        0, 5'd0,  0, 32'h0,       0, 6'd0, 32'h0001_8000, 0, 0, 0, 32'h0};
    tv[2]  = '{0, 5'd11, 32'h0,        0, 5'd0,  0, 32'h0,       0, 6'd0, 32'h0,        0, 0, 0, 32'h0};
    tv[3]  = '{0, 5'd12, 32'h0,        0, 5'd0,  0, 32'h0,       0, 6'd0, 32'h0,        0, 0, 0, 32'h0};
    tv[4]  = '{0, 5'd13, 32'h0,        0, 5'd0,  0, 32'h0,       0, 6'd0, 32'h0,        0, 0, 0, 32'h0};
    tv[5]  = '{0, 5'd14, 32'h0,        0, 5'd0,  0, 32'h0,       0, 6'd0, 32'h0,        0, 0, 0, 32'h0};
    tv[6]  = '{0, 5'd14, 32'h0,        1, 5'd8,  0, 32'h100,     0, 6'd0, 32'h0,        0, 1, 0, 32'h0};
    tv[7]  = '{0, 5'd14, 32'h0,        0, 5'd0,  0, 32'h0,       0, 6'd0, 32'h100,      0, 0, 1, 32'h100};
    tv[8]  = '{0, 5'd13, 32'h0,        0, 5'd0,  0, 32'h0,       0, 6'd0, 32'h20,       0, 0, 1, 32'h100};
    tv[9]  = '{0, 5'd12, 32'h0,        0, 5'd0,  1, 32'h0,       0, 6'd0, 32'h2,        0, 0, 1, 32'h100};
    tv[10] = '{0, 5'd12, 32'h0,        0, 5'd0,  0, 32'h0,       0, 6'd0, 32'h0,        0, 0, 0, 32'h100};
    tv[11] = '{0, 5'd13, 32'h0,        1, 5'd4,  0, 32'h204,     1, 6'd0, 32'h20,       0, 1, 0, 32'h100};
    tv[12] = '{0, 5'd13, 32'h0,        0, 5'd0,  0, 32'h0,       0, 6'd0, 32'h8000_0010, 0, 0, 1, 32'h200};
    tv[13] = '{0, 5'd14, 32'h0,        1, 5'd12, 0, 32'h300,     0, 6'd0, 32'h200,      0, 1, 1, 32'h200};
    tv[14] = '{0, 5'd13, 32'h0,        0, 5'd0,  0, 32'h0,       0, 6'd0, 32'h8000_0030, 0, 0, 1, 32'h200};
    tv[15] = '{0, 5'd14, 32'h0,        0, 5'd0,  1, 32'h0,       0, 6'd0, 32'h200,      0, 0, 1, 32'h200};
    tv[16] = '{1, 5'd12, 32'h401,      0, 5'd0,  0, 32'h0,       0, 6'd0, 32'h0,        0, 0, 0, 32'h200};
    tv[17] = '{0, 5'd12, 32'h0,        0, 5'd0,  0, 32'h0,       0, 6'd1, 32'h401,      0, 0, 0, 32'h200};
    tv[18] = '{0, 5'd13, 32'h0,        0, 5'd0,  0, 32'h400,     0, 6'd1, 32'h8000_0430, 1, 1, 0, 32'h200};
    tv[19] = '{0, 5'd13, 32'h0,        0, 5'd0,  0, 32'h0,       0, 6'd1, 32'h400,      0, 0, 1, 32'h400};
    tv[20] = '{0, 5'd13, 32'h0,        0, 5'd0,  1, 32'h0,       0, 6'd0, 32'h400,      0, 0, 1, 32'h400};
    tv[21] = '{0, 5'd13, 32'h0,        0, 5'd0,  0, 32'h0,       0, 6'd0, 32'h0,        0, 0, 0, 32'h400};
    tv[22] = '{1, 5'd12, 32'h0,        1, 5'd10, 0, 32'h500,     0, 6'd0, 32'h401,      0, 1, 0, 32'h400};
    tv[23] = '{0, 5'd12, 32'h0,        0, 5'd0,  0, 32'h0,       0, 6'd0, 32'h403,      0, 0, 1, 32'h500};
    tv[24] = '{0, 5'd13, 32'h0,        0, 5'd0,  1, 32'h0,       0, 6'd0, 32'h28,       0, 0, 1, 32'h500};
    tv[25] = '{1, 5'd13, 32'hffff_ffff, 0, 5'd0,  0, 32'h0,       0, 6'd0, 32'h28,       0, 0, 0, 32'h500};
    tv[26] = '{0, 5'd13, 32'h0,        0, 5'd0,  0, 32'h0,       0, 6'd0, 32'h328,      0, 0, 0, 32'h500};
    tv[27] = '{1, 5'd3,  32'hdead_beef, 0, 5'd0,  0, 32'h0,       0, 6'd0, 32'h0,        0, 0, 0, 32'h500};
    tv[28] = '{0, 5'd3,  32'h0,        0, 5'd0,  0, 32'h0,       0, 6'd0, 32'h0,        0, 0, 0, 32'h500};

    do_reset();
    chk("reset_handler_pc", handler_PC, 32'h0000_01a0);
    chk("reset_int_req", {31'b0, int_req}, 32'd0);

    for (int i = 0; i < 29; i++) begin
      we = tv[i].we; addr = tv[i].addr; wdata = tv[i].wdata; exc_req = tv[i].exc;
      exc_code = tv[i].code; eret = tv[i].eret; PC = tv[i].pc; is_bd = tv[i].bd; hw_int = tv[i].hw;
      @(negedge clk);
      chk($sformatf("vec%0d_rdata", i), rdata, tv[i].e_rdata);
      chk($sformatf("vec%0d_int_req", i), {31'b0, int_req}, {31'b0, tv[i].e_int});
      chk($sformatf("vec%0d_exc_enter", i), {31'b0, exc_enter}, {31'b0, tv[i].e_enter});
      chk($sformatf("vec%0d_exl", i), {31'b0, exl}, {31'b0, tv[i].e_exl});
      chk($sformatf("vec%0d_epc", i), EPC, tv[i].e_epc);
      step();
    end

    // Timer: Compare=3, Count=0 written at edge E0; TI appears after edge E7
    idle(); we = 1; addr = 5'd11; wdata = 32'd3; step();
    idle(); we = 1; addr = 5'd9; wdata = 32'd0; step();
    idle(); addr = 5'd13;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk($sformatf("timer_ti_e%0d", i), {31'b0, rdata[30]}, {31'b0, (i == 7)});
      chk($sformatf("timer_ip15_e%0d", i), {31'b0, rdata[15]}, {31'b0, (i == 7)});
    end
    we = 1; addr = 5'd11; wdata = 32'd3; step();
    idle(); addr = 5'd13; #1;
    chk("timer_ti_cleared", {31'b0, rdata[30]}, 32'd0);

    // Count wrap with Compare=0
    we = 1; addr = 5'd11; wdata = 32'd0; step();
    idle(); we = 1; addr = 5'd9; wdata = 32'hffff_ffff; step();
    idle(); addr = 5'd9; step(); step();
    chk("wrap_count", rdata, 32'd0);
    addr = 5'd13; #1;
    chk("wrap_ti_before", {31'b0, rdata[30]}, 32'd0);
    step();
    chk("wrap_ti_after", {31'b0, rdata[30]}, 32'd1);

    // Reset asserted together with an exception request
    idle(); rst = 1; exc_req = 1; exc_code = 5'd8; PC = 32'h700; step();
    rst = 0; idle(); #1;
    chk("rst_entry_exl", {31'b0, exl}, 32'd0);
    chk("rst_entry_epc", EPC, 32'd0);

    // Randomized run against the model
    do_reset();
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 6);
      case (r)
        0: addr = 5'd9;  1: addr = 5'd11; 2: addr = 5'd12; 3: addr = 5'd13;
        4: addr = 5'd14; 5: addr = 5'd15; default: addr = 5'($urandom_range(0, 31));
      endcase
      we = ($urandom_range(0, 3) == 0);
      wdata = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      if (addr == 5'd12 && $urandom_range(0, 1) == 0) wdata = {16'h0, $urandom_range(0, 255) & 8'hff, 8'h01};
      exc_req = ($urandom_range(0, 15) == 0);
      exc_code = 5'($urandom_range(0, 31));
      eret = ($urandom_range(0, 7) == 0);
      PC = $urandom & 32'hffff_fffc;
      is_bd = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 7) == 0) hw_int = 6'($urandom_range(0, 63));
      @(negedge clk);
      chk("rnd_rdata", rdata, m_read(addr));
      chk("rnd_int_req", {31'b0, int_req}, {31'b0, m_int()});
      chk("rnd_exc_enter", {31'b0, exc_enter}, {31'b0, exc_req | m_int()});
      chk("rnd_epc", EPC, m_epc);
      chk("rnd_exl", {31'b0, exl}, {31'b0, m_exl});
      @(posedge clk);
      m_step();
      #1;
    end
    chk("rnd_handler_pc", handler_PC, 32'h0000_01a0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
